// File: rtl/pio_pkg.sv
// Shared definitions for the parallel-I/O peripheral family: bus widths,
// register word addresses and the capture/interrupt mode encodings.
package pio_pkg;

  localparam int unsigned BUS_W  = 32;
  localparam int unsigned ADDR_W = 2;

  // Register word addresses
  localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD    = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

  // Edge capture modes
  localparam int unsigned EDGE_NONE = 0;
  localparam int unsigned EDGE_RISE = 1;
  localparam int unsigned EDGE_FALL = 2;
  localparam int unsigned EDGE_ANY  = 3;

  // Interrupt source modes
  localparam int unsigned IRQ_NONE  = 0;
  localparam int unsigned IRQ_LEVEL = 1;
  localparam int unsigned IRQ_EDGE  = 2;

endpackage : pio_pkg

// File: rtl/pio_sync_chain.sv
// Parametrised multi-bit flop synchroniser.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (stages clear to 0)
//   d_i          : WIDTH-bit input, may be asynchronous to clk
//   q_o          : last synchroniser stage; equals d_i when DEPTH = 0
module pio_sync_chain #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    // Zero depth: input is used directly, no flops at all
    assign q_o = d_i;
  end else begin : g_chain
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int unsigned k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int unsigned k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule : pio_sync_chain

// File: rtl/pio_in_capture.sv
// Avalon-MM input PIO with synchroniser, per-bit edge capture (W1C) and
// maskable level/edge interrupt.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   address               : register word address (0 DATA, 2 IRQMASK, 3 EDGECAP)
//   chipselect, write_n   : write strobe is chipselect & ~write_n
//   writedata             : write data, bits above DATA_WIDTH ignored
//   in_port               : external input, may be asynchronous
//   readdata              : registered read data, 1-cycle latency, zero-extended
//   irq                   : registered interrupt request
module pio_in_capture
  import pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned IRQ_TYPE    = IRQ_EDGE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [BUS_W-1:0]      writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [BUS_W-1:0]      readdata,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] sync_c;
  logic [DATA_WIDTH-1:0] wr_val_c;
  logic [DATA_WIDTH-1:0] event_c;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] capture_q, capture_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [BUS_W-1:0]      readdata_q, readdata_d;
  logic                  irq_q, irq_d;
  logic                  primed_q;
  logic                  wr_en_c;

  pio_sync_chain #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (in_port),
    .q_o     (sync_c)
  );

  assign wr_en_c  = chipselect & ~write_n;
  assign wr_val_c = writedata[DATA_WIDTH-1:0];

  // Edge events; held off until prev holds a real sample after reset
  always_comb begin : edge_sel
    event_c = '0;
    if (primed_q) begin
      case (EDGE_TYPE)
        EDGE_RISE: event_c = sync_c & ~prev_q;
        EDGE_FALL: event_c = ~sync_c & prev_q;
        EDGE_ANY:  event_c = sync_c ^ prev_q;
        default:   event_c = '0;
      endcase
    end
  end

  // Register updates, read mux and interrupt source
  always_comb begin : next_state
    mask_d     = mask_q;
    capture_d  = capture_q;
    readdata_d = '0;
    irq_d      = 1'b0;

    if (wr_en_c && (address == ADDR_IRQMASK)) mask_d = wr_val_c;
    if (wr_en_c && (address == ADDR_EDGECAP)) capture_d = capture_q & ~wr_val_c;
    // A new event on a bit overrides a same-cycle clear of that bit
    capture_d = capture_d | event_c;

    case (address)
      ADDR_DATA:    readdata_d = BUS_W'(sync_c);
      ADDR_IRQMASK: readdata_d = BUS_W'(mask_q);
      ADDR_EDGECAP: readdata_d = BUS_W'(capture_q);
      default:      readdata_d = '0;
    endcase

    case (IRQ_TYPE)
      IRQ_LEVEL: irq_d = |(sync_c & mask_q);
      IRQ_EDGE:  irq_d = |(capture_q & mask_q);
      default:   irq_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      primed_q   <= 1'b0;
      capture_q  <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      prev_q     <= sync_c;
      primed_q   <= 1'b1;
      capture_q  <= capture_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule : pio_in_capture

// File: tb/tb_pio_in_capture.sv
// Bench for pio_in_capture: five configurations side by side, directed
// sequences, a vector table and a randomized run against a history-based model.
module tb_pio_in_capture;

  localparam int NDUT = 5;
  localparam int DW_T [NDUT] = '{32, 32, 32, 32, 8};
  localparam int ST_T [NDUT] = '{ 2,  2,  1,  0, 2};
  localparam int ET_T [NDUT] = '{ 1,  2,  0,  3, 1};
  localparam int IT_T [NDUT] = '{ 2,  2,  0,  2, 1};

  logic              clk = 1'b0;
  logic              reset_n;
  logic [1:0]        addr  [NDUT];
  logic              cs    [NDUT];
  logic              wr_n  [NDUT];
  logic [31:0]       wdata [NDUT];
  logic [31:0]       inp   [NDUT];
  logic [31:0]       rd    [NDUT];
  logic [NDUT-1:0]   irq_v;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    pio_in_capture #(
      .DATA_WIDTH  (DW_T[g]),
      .SYNC_STAGES (ST_T[g]),
      .EDGE_TYPE   (ET_T[g]),
      .IRQ_TYPE    (IT_T[g])
    ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (addr[g]),
      .chipselect (cs[g]),
      .write_n    (wr_n[g]),
      .writedata  (wdata[g]),
      .in_port    (inp[g][DW_T[g]-1:0]),
      .readdata   (rd[g]),
      .irq        (irq_v[g])
    );
  end

  function automatic logic [31:0] wmask(input int dw);
    return (dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: sync is simply the input sampled SYNC_STAGES clocks ago
  logic [31:0] hist    [NDUT][5];
  logic [31:0] m_cap   [NDUT];
  logic [31:0] m_mask  [NDUT];
  logic [31:0] m_rd    [NDUT];
  logic        m_irq   [NDUT];
  logic        m_primed[NDUT];
  logic [31:0] wm, sy, pv, ev, clr;
  logic        wen;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NDUT; i++) begin
        for (int k = 0; k < 5; k++) hist[i][k] = '0;
        m_cap[i] = '0; m_mask[i] = '0; m_rd[i] = '0; m_irq[i] = 1'b0; m_primed[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NDUT; i++) begin
        wm = wmask(DW_T[i]);
        for (int k = 4; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = inp[i] & wm;
        sy = hist[i][ST_T[i]];
        pv = hist[i][ST_T[i]+1];
        case (ET_T[i])
          1: ev = sy & ~pv;
          2: ev = ~sy & pv;
          3: ev = sy ^ pv;
          default: ev = '0;
        endcase
        if (!m_primed[i]) ev = '0;
        wen = cs[i] && !wr_n[i];
        clr = (wen && addr[i] == 2'd3) ? (wdata[i] & wm) : '0;
        case (addr[i])
          2'd0: m_rd[i] = sy;
          2'd2: m_rd[i] = m_mask[i];
          2'd3: m_rd[i] = m_cap[i];
          default: m_rd[i] = '0;
        endcase
        if (IT_T[i] == 1)      m_irq[i] = |(sy & m_mask[i]);
        else if (IT_T[i] == 2) m_irq[i] = |(m_cap[i] & m_mask[i]);
        else                   m_irq[i] = 1'b0;
        m_cap[i] = (m_cap[i] & ~clr) | ev;
        if (wen && addr[i] == 2'd2) m_mask[i] = wdata[i] & wm;
        m_primed[i] = 1'b1;
      end
    end
  end

  // Continuous comparison of every instance against the model
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("model_rd[%0d]", i), rd[i], m_rd[i]);
      chk($sformatf("model_irq[%0d]", i), 32'(irq_v[i]), 32'(m_irq[i]));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_wr(input int d, input logic [1:0] a, input logic [31:0] v);
    addr[d] = a; cs[d] = 1'b1; wr_n[d] = 1'b0; wdata[d] = v;
    tick(1);
    cs[d] = 1'b0; wr_n[d] = 1'b1; wdata[d] = '0;
  endtask

  task automatic rd_chk(input int d, input logic [1:0] a, input logic [31:0] exp, input string nm);
    addr[d] = a;
    tick(1);
    chk(nm, rd[d], exp);
  endtask

  typedef struct {
    logic [7:0]  in_v;
    logic [31:0] mask;
    logic [1:0]  a;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{8'h80, 32'h0000_00FF, 2'd0, 32'h80, 1'b1};
    tbl[1] = '{8'h80, 32'hFFFF_FF7F, 2'd2, 32'h7F, 1'b0};
    tbl[2] = '{8'h3C, 32'h0000_0004, 2'd0, 32'h3C, 1'b1};
    tbl[3] = '{8'h3C, 32'h0000_00C3, 2'd1, 32'h00, 1'b0};
    tbl[4] = '{8'h01, 32'hFFFF_FF01, 2'd2, 32'h01, 1'b1};
    tbl[5] = '{8'h00, 32'h0000_00FF, 2'd0, 32'h00, 1'b0};
    tbl[6] = '{8'hFF, 32'h0000_0000, 2'd2, 32'h00, 1'b0};

    reset_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      addr[i] = '0; cs[i] = 1'b0; wr_n[i] = 1'b1; wdata[i] = '0; inp[i] = '0;
    end
    inp[1] = 32'hA5A5_0001;
    tick(3);
    chk("reset_irq", 32'(irq_v), 32'd0);
    chk("reset_rd0", rd[0], 32'd0);
    reset_n = 1'b1;

    // Reset and read latency on the falling-edge instance
    tick(2);
    tick(1);
    chk("t1_data", rd[1], 32'hA5A5_0001);
    rd_chk(1, 2'd3, 32'd0, "t1_edgecap");
    chk("t1_irq", 32'(irq_v[1]), 32'd0);

    // Rising capture, exact irq latency, W1C
    do_wr(0, 2'd2, 32'h1);
    addr[0] = 2'd3;
    inp[0]  = 32'h1;
    tick(3);
    chk("t2_irq_early", 32'(irq_v[0]), 32'd0);
    tick(1);
    chk("t2_irq", 32'(irq_v[0]), 32'd1);
    chk("t2_cap", rd[0], 32'h1);
    do_wr(0, 2'd3, 32'h1);
    addr[0] = 2'd3;
    tick(1);
    chk("t2_cap_clr", rd[0], 32'd0);
    chk("t2_irq_clr", 32'(irq_v[0]), 32'd0);

    // Set beats a same-cycle clear
    inp[0] = 32'h9;
    tick(2);
    do_wr(0, 2'd3, 32'h8);
    addr[0] = 2'd3;
    tick(1);
    chk("t3_set_wins", rd[0], 32'h8);
    do_wr(0, 2'd3, 32'h8);

    // Mode sweep
    do_wr(1, 2'd3, 32'hFFFF_FFFF);
    inp[1] = 32'hA5A5_0000;
    tick(4);
    rd_chk(1, 2'd3, 32'h1, "t4_fall_cap");
    do_wr(1, 2'd3, 32'h1);
    inp[1] = 32'hA5A5_0001;
    tick(4);
    rd_chk(1, 2'd3, 32'h0, "t4_fall_ignores_rise");
    do_wr(3, 2'd3, 32'hFFFF_FFFF);
    inp[3] = 32'h10;
    tick(2);
    rd_chk(3, 2'd3, 32'h10, "t4_any_rise");
    do_wr(3, 2'd3, 32'h10);
    inp[3] = 32'h0;
    tick(2);
    rd_chk(3, 2'd3, 32'h10, "t4_any_fall");
    inp[3] = 32'h1234;
    rd_chk(3, 2'd0, 32'h1234, "t4_bypass_data");
    inp[2] = 32'hFFFF_FFFF;
    tick(3);
    inp[2] = 32'h0;
    tick(3);
    rd_chk(2, 2'd3, 32'h0, "t4_none_cap");
    chk("t4_none_irq", 32'(irq_v[2]), 32'd0);

    // Level irq, narrow width: vector table
    for (int r = 0; r < 7; r++) begin
      do_wr(4, 2'd2, tbl[r].mask);
      inp[4]  = 32'(tbl[r].in_v);
      addr[4] = tbl[r].a;
      tick(4);
      chk($sformatf("tbl_rd[%0d]", r), rd[4], tbl[r].exp_rd);
      chk($sformatf("tbl_irq[%0d]", r), 32'(irq_v[4]), 32'(tbl[r].exp_irq));
    end
    do_wr(4, 2'd2, 32'hFF);
    inp[4] = 32'h80; addr[4] = 2'd0;
    tick(4);
    chk("t5_level_irq", 32'(irq_v[4]), 32'd1);
    chk("t5_upper_zero", rd[4] & 32'hFFFF_FF00, 32'd0);
    do_wr(4, 2'd2, 32'h7F);
    chk("t5_irq_hold", 32'(irq_v[4]), 32'd1);
    tick(1);
    chk("t5_irq_drop", 32'(irq_v[4]), 32'd0);

    // Reset mid-operation
    do_wr(0, 2'd2, 32'hF0);
    inp[0] = 32'hF9; addr[0] = 2'd3;
    inp[3] = 32'hF;  addr[3] = 2'd3;
    tick(5);
    chk("t6_cap_pre", rd[0], 32'hF0);
    chk("t6_irq_pre", 32'(irq_v[0]), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_irq_async", 32'(irq_v[0]), 32'd0);
    chk("t6_rd_async", rd[0], 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick(1);
    tick(1);
    chk("t6_no_cap_first", rd[0], 32'd0);
    chk("t6_bypass_primed", rd[3], 32'd0);
    tick(1);
    chk("t6_bypass_primed2", rd[3], 32'd0);

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < NDUT; d++) begin
        cs[d]    = 1'($urandom % 2);
        wr_n[d]  = 1'($urandom % 2);
        addr[d]  = 2'($urandom % 4);
        wdata[d] = $urandom;
        if ($urandom % 3 == 0) inp[d] = inp[d] ^ (32'd1 << ($urandom % 32));
        if ($urandom % 64 == 0) inp[d] = $urandom;
      end
      if ($urandom % 250 == 0) begin
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
      end
      tick(1);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_pio_in_capture
